// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter in front of one combinational ALU, with a one-entry
// response register returned to the owning requester under valid/ready flow control.
module alu_share_arbiter #(
    parameter int WIDTH        = 32,
    parameter int STARVE_LIMIT = 4,
    localparam int CNT_W       = $clog2(STARVE_LIMIT + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    input  logic             rsp0_ready,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             dbg_state,
    output logic [CNT_W-1:0] dbg_starve_cnt
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; ready never waits on anything registered later than this cycle.

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state, state_next;
    logic             owner;
    logic [CNT_W-1:0] starve_cnt;
    logic             owner_ready;
    logic             slot_free;
    logic             starved;
    logic             grant0, grant1;
    logic             accept;

    assign owner_ready = owner ? rsp1_ready : rsp0_ready;
    assign slot_free   = (state == IDLE) || owner_ready;
    assign starved     = (starve_cnt == CNT_W'(STARVE_LIMIT)) && req1_valid;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (slot_free) begin
            if (req1_valid && (starved || !req0_valid)) begin
                grant1 = 1'b1;
            end else if (req0_valid) begin
                grant0 = 1'b1;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign accept     = grant0 || grant1;

    // Without a grant the mux rests on req0; the ALU result is then ignored.
    always_comb begin
        alu_A  = req0_a;
        alu_B  = req0_b;
        alu_op = req0_op;
        if (grant1) begin
            alu_A  = req1_a;
            alu_B  = req1_b;
            alu_op = req1_op;
        end
    end

    always_comb begin
        state_next = state;
        if (accept) begin
            state_next = HOLD;
        end else if ((state == HOLD) && owner_ready) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            owner    <= 1'b0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                owner    <= grant1;
                rsp_data <= alu_out;
                rsp_err  <= (alu_op == 4'hF);
            end
        end
    end

    // Counts consecutive cycles req1 is left waiting, saturating at the limit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (!req1_valid || grant1) begin
            starve_cnt <= '0;
        end else if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    assign rsp0_valid     = (state == HOLD) && !owner;
    assign rsp1_valid     = (state == HOLD) && owner;
    assign dbg_state      = state;
    assign dbg_starve_cnt = starve_cnt;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: per-cycle vector table with expected grants and
// starvation count, a response scoreboard, and a hand-written mid-hold reset sequence.
module tb_alu_share_arbiter;

    localparam int W = 32;
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_XXX = 4'hF;

    logic         clk, reset_n;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]   req0_op, req1_op, alu_op;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [W-1:0] alu_A, alu_B, alu_out, rsp_data;
    logic         rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready, rsp_err;
    logic         dbg_state;
    logic [2:0]   dbg_starve_cnt;

    alu_share_arbiter #(.WIDTH(W), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op), .alu_out(alu_out),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
    );

    function automatic logic [W-1:0] alu_f(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            default: return '0;
        endcase
    endfunction

    assign alu_out = alu_f(alu_op, alu_A, alu_B);

    // ---- clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---- scoreboard: {owner, err, data}
    logic [W+1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(string name, int row, logic [W+1:0] act, logic [W+1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    typedef struct {
        logic         r0v;
        logic [3:0]   r0op;
        logic [W-1:0] r0a, r0b;
        logic         r1v;
        logic [3:0]   r1op;
        logic [W-1:0] r1a, r1b;
        logic         s0r, s1r;
        logic         x0, x1;
        logic [2:0]   xcnt;
    } vec_t;

    function automatic vec_t mk(logic r0v, logic [3:0] r0op, logic [W-1:0] r0a, logic [W-1:0] r0b,
                                logic r1v, logic [3:0] r1op, logic [W-1:0] r1a, logic [W-1:0] r1b,
                                logic s0r, logic s1r, logic x0, logic x1, logic [2:0] xcnt);
        vec_t v;
        v.r0v = r0v; v.r0op = r0op; v.r0a = r0a; v.r0b = r0b;
        v.r1v = r1v; v.r1op = r1op; v.r1a = r1a; v.r1b = r1b;
        v.s0r = s0r; v.s1r = s1r; v.x0 = x0; v.x1 = x1; v.xcnt = xcnt;
        return v;
    endfunction

    // ---- driver
    task automatic drive(vec_t v);
        req0_valid = v.r0v; req0_op = v.r0op; req0_a = v.r0a; req0_b = v.r0b;
        req1_valid = v.r1v; req1_op = v.r1op; req1_a = v.r1a; req1_b = v.r1b;
        rsp0_ready = v.s0r; rsp1_ready = v.s1r;
    endtask

    // Mid-cycle check of one row, then scoreboard pop/push for the coming edge.
    task automatic check_row(vec_t v, int row);
        logic         hv;
        logic [W+1:0] head;
        check("req0_ready", row, {33'd0, req0_ready}, {33'd0, v.x0});
        check("req1_ready", row, {33'd0, req1_ready}, {33'd0, v.x1});
        check("starve_cnt", row, {31'd0, dbg_starve_cnt}, {31'd0, v.xcnt});
        hv   = (exp_q.size() > 0);
        head = hv ? exp_q[0] : '0;
        check("rsp0_valid", row, {33'd0, rsp0_valid}, {33'd0, hv && !head[W+1]});
        check("rsp1_valid", row, {33'd0, rsp1_valid}, {33'd0, hv && head[W+1]});
        if (hv) begin
            check("rsp_err_data", row, {head[W+1], rsp_err, rsp_data}, head);
            if (head[W+1] ? v.s1r : v.s0r) void'(exp_q.pop_front());
        end
        if (v.x0) exp_q.push_back({1'b0, v.r0op == OP_XXX, alu_f(v.r0op, v.r0a, v.r0b)});
        if (v.x1) exp_q.push_back({1'b1, v.r1op == OP_XXX, alu_f(v.r1op, v.r1a, v.r1b)});
    endtask

    vec_t vecs[$];
    vec_t idle_v;

    initial begin
        logic [W-1:0] ra, rb;
        idle_v = mk(0, OP_ADD, 0, 0, 0, OP_ADD, 0, 0, 1, 1, 0, 0, 0);
        drive(idle_v);
        reset_n = 1'b0;

        // 1: single ADD from req0
        vecs.push_back(mk(1, OP_ADD, 5, 7, 0, OP_ADD, 0, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, OP_ADD, 0, 0, 0, OP_ADD, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, OP_ADD, 0, 0, 0, OP_ADD, 0, 0, 1, 1, 0, 0, 0));
        // 2: both valid in IDLE, req0 first then req1
        vecs.push_back(mk(1, OP_SUB, 9, 3, 1, OP_XOR, 32'hF0, 32'h0F, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, OP_ADD, 0, 0, 1, OP_XOR, 32'hF0, 32'h0F, 1, 1, 0, 1, 1));
        vecs.push_back(mk(0, OP_ADD, 0, 0, 0, OP_ADD, 0, 0, 1, 1, 0, 0, 0));
        // 3: req0 streaming, req1 waiting until starvation limit
        for (int i = 0; i < 6; i++) begin
            ra = W'($urandom_range(0, 1000));
            rb = W'($urandom_range(0, 1000));
            vecs.push_back(mk(1, OP_ADD, ra, rb, 1, OP_OR, 32'h100 + W'(i), 32'h3,
                              1, 1, i != 4, i == 4, (i == 5) ? 3'd0 : 3'(i)));
        end
        vecs.push_back(mk(0, OP_ADD, 0, 0, 0, OP_ADD, 0, 0, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, OP_ADD, 0, 0, 0, OP_ADD, 0, 0, 1, 1, 0, 0, 0));
        // 4: response held by rsp0_ready=0; non-owner ready ignored
        vecs.push_back(mk(1, OP_AND, 32'hFF00, 32'h0FF0, 0, OP_ADD, 0, 0, 0, 1, 1, 0, 0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1, OP_SUB, 50, 8, 1, OP_ADD, 40, 2, 0, 1, 0, 0, 3'(i)));
        vecs.push_back(mk(1, OP_SUB, 50, 8, 1, OP_ADD, 40, 2, 1, 1, 1, 0, 3));
        vecs.push_back(mk(1, OP_XOR, 1, 3, 1, OP_ADD, 40, 2, 1, 0, 0, 1, 4));
        vecs.push_back(mk(0, OP_ADD, 0, 0, 0, OP_ADD, 0, 0, 0, 1, 0, 0, 0));
        // 5: ALU_XXX flags rsp_err, next ADD clears it
        vecs.push_back(mk(0, OP_ADD, 0, 0, 1, OP_XXX, 11, 22, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, OP_ADD, 0, 0, 0, OP_ADD, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, OP_ADD, 0, 0, 1, OP_ADD, 2, 3, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, OP_ADD, 0, 0, 0, OP_ADD, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, OP_ADD, 0, 0, 0, OP_ADD, 0, 0, 1, 1, 0, 0, 0));

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_rsp0_valid", -1, {33'd0, rsp0_valid}, '0);
        check("reset_rsp1_valid", -1, {33'd0, rsp1_valid}, '0);
        check("reset_state", -1, {33'd0, dbg_state}, '0);
        check("reset_rsp_data", -1, {rsp_err, 1'b0, rsp_data}, '0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        foreach (vecs[i]) begin
            @(posedge clk);
            #1 drive(vecs[i]);
            @(negedge clk);
            check_row(vecs[i], i);
        end
        check("queue_drained", -2, W'(exp_q.size()), '0);

        // 6: asynchronous reset in the middle of HOLD
        @(posedge clk);
        #1 drive(mk(1, OP_ADD, 100, 23, 0, OP_ADD, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        check("r6_accept", 100, {33'd0, req0_ready}, 34'd1);
        @(posedge clk);
        #1 drive(mk(0, OP_ADD, 0, 0, 0, OP_ADD, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        check("r6_hold", 101, {rsp0_valid, rsp1_valid, rsp_data}, {2'b10, 32'd123});
        #2 reset_n = 1'b0;
        #1;
        check("r6_async_valid", 102, {32'd0, rsp0_valid, rsp1_valid}, '0);
        check("r6_async_data", 102, {1'b0, rsp_err, rsp_data}, '0);
        check("r6_async_state", 102, {33'd0, dbg_state}, '0);
        exp_q.delete();
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("r6_post_valid", 103 + i, {32'd0, rsp0_valid, rsp1_valid}, '0);
            check("r6_post_state", 103 + i, {33'd0, dbg_state}, '0);
            @(posedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
